// File: rtl/lc3_mem_pkg.sv
// Shared encodings for the LC-3 MAR access unit and the address muxes.
package lc3_mem_pkg;

  // Address source select encodings
  localparam logic [1:0] SEL_IMM  = 2'd0;
  localparam logic [1:0] SEL_OFF  = 2'd1;
  localparam logic [1:0] SEL_BUS  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  // Memory access FSM states (2-bit)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ABORT  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/lc3_mar_access_unit_if.sv
// Datapath/control side bundle of the MAR access unit.
// The master drives selects and requests; the slave is the access unit.
interface lc3_mar_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 8
);
  logic [1:0]        i_sel;
  logic [ADDR_W-1:0] i_offset_addr;
  logic [IMM_W-1:0]  i_imm;
  logic [ADDR_W-1:0] i_bus;
  logic              i_ld_mar;
  logic              i_mem_req;
  logic              i_mem_we;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mux_out;
  logic [ADDR_W-1:0] o_mar;
  logic              o_mem_en;
  logic              o_mem_we;
  logic              o_busy;
  logic              o_done;
  logic              o_timeout;

  modport master (
    output i_sel, i_offset_addr, i_imm, i_bus, i_ld_mar, i_mem_req, i_mem_we, i_mem_ready,
    input  o_mux_out, o_mar, o_mem_en, o_mem_we, o_busy, o_done, o_timeout
  );

  modport slave (
    input  i_sel, i_offset_addr, i_imm, i_bus, i_ld_mar, i_mem_req, i_mem_we, i_mem_ready,
    output o_mux_out, o_mar, o_mem_en, o_mem_we, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/lc3_addr_mux_p.sv
// Parametrised 4:1 address mux with immediate extension.
// Kept free of state so the PC mux can reuse it unchanged.
module lc3_addr_mux_p
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int IMM_W    = 8,
  parameter int IMM_SEXT = 0
) (
  input  logic [1:0]        sel,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] offset_addr,
  input  logic [ADDR_W-1:0] bus,
  input  logic [ADDR_W-1:0] hold,
  output logic [ADDR_W-1:0] mux_out
);

  logic [ADDR_W-1:0] imm_ext;

  // Zero-extension suits TRAP vectors; sign-extension suits PC-relative fields
  generate
    if (IMM_SEXT != 0) begin : g_sext
      assign imm_ext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_zext
      assign imm_ext = {{(ADDR_W-IMM_W){1'b0}}, imm};
    end
  endgenerate

  // Source selection; HOLD recirculates the caller's current register
  always_comb begin
    mux_out = hold;
    case (sel)
      SEL_IMM:  mux_out = imm_ext;
      SEL_OFF:  mux_out = offset_addr;
      SEL_BUS:  mux_out = bus;
      SEL_HOLD: mux_out = hold;
      default:  mux_out = hold;
    endcase
  end

endmodule

// File: rtl/lc3_mar_access_unit.sv
// LC-3 MAR access unit: address mux, MAR register and a single-outstanding
// memory access FSM with ready handshake and timeout abort.
module lc3_mar_access_unit
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int IMM_W    = 8,
  parameter int IMM_SEXT = 0,
  parameter int TIMEOUT  = 15
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  lc3_mar_access_unit_if.slave mif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t        state_reg;
  logic [ADDR_W-1:0] mar_reg;
  logic [ADDR_W-1:0] mux_out;
  logic [CNT_W-1:0]  cnt_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic              done_reg;
  logic              timeout_reg;

  lc3_addr_mux_p #(
    .ADDR_W   (ADDR_W),
    .IMM_W    (IMM_W),
    .IMM_SEXT (IMM_SEXT)
  ) u_mux (
    .sel         (mif.i_sel),
    .imm         (mif.i_imm),
    .offset_addr (mif.i_offset_addr),
    .bus         (mif.i_bus),
    .hold        (mar_reg),
    .mux_out     (mux_out)
  );

  // MAR load and access FSM; MAR only moves in IDLE so it is stable during an access
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      mar_reg     <= '0;
      cnt_reg     <= '0;
      mem_en_reg  <= 1'b0;
      mem_we_reg  <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mif.i_ld_mar) mar_reg <= mux_out;
          if (mif.i_mem_req) begin
            state_reg  <= ST_ACCESS;
            mem_en_reg <= 1'b1;
            mem_we_reg <= mif.i_mem_we;
            cnt_reg    <= '0;
          end
        end
        ST_ACCESS: begin
          cnt_reg <= cnt_reg + CNT_ONE;
          // Ready is tested first so a completion on the last allowed cycle wins
          if (mif.i_mem_ready) begin
            state_reg  <= ST_DONE;
            done_reg   <= 1'b1;
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= ST_ABORT;
            timeout_reg <= 1'b1;
            mem_en_reg  <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        ST_DONE:  state_reg <= ST_IDLE;
        ST_ABORT: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mif.o_mux_out = mux_out;
  assign mif.o_mar     = mar_reg;
  assign mif.o_mem_en  = mem_en_reg;
  assign mif.o_mem_we  = mem_we_reg;
  assign mif.o_busy    = (state_reg != ST_IDLE);
  assign mif.o_done    = done_reg;
  assign mif.o_timeout = timeout_reg;

endmodule

// File: tb/tb_lc3_mar_access_unit.sv
// Bench for lc3_mar_access_unit: two instances (zero-extend / sign-extend,
// different timeouts) share one stimulus stream; each is compared every
// cycle against a transaction-level reference model.
module tb_lc3_mar_access_unit;

  localparam int TO_Z = 4;
  localparam int TO_S = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  sel;
  logic [15:0] off_addr;
  logic [15:0] bus_v;
  logic [7:0]  imm;
  logic        ld, req, we, ready;

  lc3_mar_access_unit_if #(.ADDR_W(16), .IMM_W(8)) if_z ();
  lc3_mar_access_unit_if #(.ADDR_W(16), .IMM_W(8)) if_s ();

  assign if_z.i_sel = sel;        assign if_s.i_sel = sel;
  assign if_z.i_offset_addr = off_addr; assign if_s.i_offset_addr = off_addr;
  assign if_z.i_imm = imm;        assign if_s.i_imm = imm;
  assign if_z.i_bus = bus_v;      assign if_s.i_bus = bus_v;
  assign if_z.i_ld_mar = ld;      assign if_s.i_ld_mar = ld;
  assign if_z.i_mem_req = req;    assign if_s.i_mem_req = req;
  assign if_z.i_mem_we = we;      assign if_s.i_mem_we = we;
  assign if_z.i_mem_ready = ready; assign if_s.i_mem_ready = ready;

  lc3_mar_access_unit #(.ADDR_W(16), .IMM_W(8), .IMM_SEXT(0), .TIMEOUT(TO_Z)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .mif(if_z));
  lc3_mar_access_unit #(.ADDR_W(16), .IMM_W(8), .IMM_SEXT(1), .TIMEOUT(TO_S)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .mif(if_s));

  int checks = 0;
  int errors = 0;

  // Reference model: waited = completed access cycles (-1 when no access),
  // pulse = 0 none / 1 done / 2 timeout shown this cycle.
  int          m_waited [2];
  int          m_pulse  [2];
  logic [15:0] m_mar    [2];
  logic        m_we     [2];

  // Observed outputs of the most recent cycle
  logic [15:0] g_mux [2];
  logic [15:0] g_mar [2];
  logic        g_en [2], g_we [2], g_busy [2], g_done [2], g_to [2];

  int en_cnt [2], we_cnt [2], done_cnt [2], to_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mux(int k, logic [15:0] mar);
    int unsigned v;
    if (sel == 2'd0) begin
      v = imm;
      if (k == 1 && imm >= 8'd128) v = v + 32'hFF00;
      return v[15:0];
    end
    if (sel == 2'd1) return off_addr;
    if (sel == 2'd2) return bus_v;
    return mar;
  endfunction

  function automatic void model_edge(int k);
    int lim;
    lim = (k == 0) ? TO_Z : TO_S;
    if (!rst_n) begin
      m_waited[k] = -1; m_pulse[k] = 0; m_mar[k] = 16'h0; m_we[k] = 1'b0;
    end else if (m_pulse[k] != 0) begin
      m_pulse[k] = 0;
    end else if (m_waited[k] >= 0) begin
      m_waited[k]++;
      if (ready) begin m_waited[k] = -1; m_pulse[k] = 1; end
      else if (m_waited[k] == lim) begin m_waited[k] = -1; m_pulse[k] = 2; end
    end else begin
      if (ld) m_mar[k] = ref_mux(k, m_mar[k]);
      if (req) begin m_waited[k] = 0; m_we[k] = we; end
    end
  endfunction

  task automatic compare_all();
    string nm;
    logic  acc;
    g_mux[0] = if_z.o_mux_out; g_mar[0] = if_z.o_mar; g_en[0] = if_z.o_mem_en;
    g_we[0] = if_z.o_mem_we; g_busy[0] = if_z.o_busy; g_done[0] = if_z.o_done; g_to[0] = if_z.o_timeout;
    g_mux[1] = if_s.o_mux_out; g_mar[1] = if_s.o_mar; g_en[1] = if_s.o_mem_en;
    g_we[1] = if_s.o_mem_we; g_busy[1] = if_s.o_busy; g_done[1] = if_s.o_done; g_to[1] = if_s.o_timeout;
    for (int k = 0; k < 2; k++) begin
      nm  = (k == 0) ? "z" : "s";
      acc = (m_waited[k] >= 0);
      check({nm, ".mux"},  32'(g_mux[k]),  32'(ref_mux(k, m_mar[k])));
      check({nm, ".mar"},  32'(g_mar[k]),  32'(m_mar[k]));
      check({nm, ".en"},   32'(g_en[k]),   32'(acc));
      check({nm, ".we"},   32'(g_we[k]),   32'(acc && m_we[k]));
      check({nm, ".busy"}, 32'(g_busy[k]), 32'(acc || m_pulse[k] != 0));
      check({nm, ".done"}, 32'(g_done[k]), 32'(m_pulse[k] == 1));
      check({nm, ".tmo"},  32'(g_to[k]),   32'(m_pulse[k] == 2));
      en_cnt[k]   += int'(g_en[k]);
      we_cnt[k]   += int'(g_we[k]);
      done_cnt[k] += int'(g_done[k]);
      to_cnt[k]   += int'(g_to[k]);
      if (m_pulse[k] != 0)
        $display("txn %s addr=%h we=%0d result=%s", nm, m_mar[k], m_we[k],
                 (m_pulse[k] == 1) ? "done" : "timeout");
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      en_cnt[k] = 0; we_cnt[k] = 0; done_cnt[k] = 0; to_cnt[k] = 0;
    end
  endtask

  task automatic quiet();
    ld = 1'b0; req = 1'b0; we = 1'b0; ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'd3; off_addr = 16'h0; bus_v = 16'h0; imm = 8'h0;
    quiet();
    for (int k = 0; k < 2; k++) begin
      m_waited[k] = -1; m_pulse[k] = 0; m_mar[k] = 16'h0; m_we[k] = 1'b0;
    end
    clear_counts();
    @(negedge clk);

    // Reset state
    step(); step();
    check("rst.mar", 32'(g_mar[0]), 32'h0);
    check("rst.busy", 32'(g_busy[1]), 32'h0);
    rst_n = 1'b1;
    step();

    // Immediate extension: 8'h85 -> zero- / sign-extended MAR
    sel = 2'd0; imm = 8'h85; ld = 1'b1;
    step();
    ld = 1'b0;
    check("zext.mar", 32'(g_mar[0]), 32'h0085);
    check("sext.mar", 32'(g_mar[1]), 32'hFF85);
    step();

    // Read handshake: load and request together, ready after 3 enable cycles
    clear_counts();
    sel = 2'd1; off_addr = 16'h3001; ld = 1'b1; req = 1'b1; we = 1'b0;
    step();
    quiet();
    step(); step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("rd.done_busy", 32'(g_busy[0]), 32'h1);
    step();
    for (int k = 0; k < 2; k++) begin
      check("rd.mar", 32'(g_mar[k]), 32'h3001);
      check("rd.en_cycles", 32'(en_cnt[k]), 32'd3);
      check("rd.done_cnt", 32'(done_cnt[k]), 32'd1);
    end

    // Timeout: write never answered
    clear_counts();
    req = 1'b1; we = 1'b1;
    step();
    quiet();
    for (int i = 0; i < 9; i++) step();
    check("to.z_en", 32'(en_cnt[0]), 32'(TO_Z));
    check("to.s_en", 32'(en_cnt[1]), 32'(TO_S));
    for (int k = 0; k < 2; k++) begin
      check("to.we_cycles", 32'(we_cnt[k]), 32'(en_cnt[k]));
      check("to.tmo_cnt", 32'(to_cnt[k]), 32'd1);
      check("to.done_cnt", 32'(done_cnt[k]), 32'd0);
      check("to.idle", 32'(g_busy[k]), 32'h0);
    end

    // Ready on access cycle 4 (the last one for the TIMEOUT=4 instance)
    clear_counts();
    req = 1'b1;
    step();
    quiet();
    step(); step(); step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      check("last.done_cnt", 32'(done_cnt[k]), 32'd1);
      check("last.tmo_cnt", 32'(to_cnt[k]), 32'd0);
    end

    // Ignored inputs while busy
    sel = 2'd1; off_addr = 16'h1234; ld = 1'b1;
    step();
    clear_counts();
    ld = 1'b0; req = 1'b1;
    step();
    sel = 2'd2; bus_v = 16'hBEEF; ld = 1'b1; req = 1'b1;
    step();
    ld = 1'b0; req = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 2; k++) begin
      check("ign.mar", 32'(g_mar[k]), 32'h1234);
      check("ign.done_cnt", 32'(done_cnt[k]), 32'd1);
      check("ign.en_cycles", 32'(en_cnt[k]), 32'd2);
    end

    // Reset in access cycle 2, then a fresh access
    clear_counts();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      check("rstm.en", 32'(g_en[k]), 32'h0);
      check("rstm.mar", 32'(g_mar[k]), 32'h0);
      check("rstm.busy", 32'(g_busy[k]), 32'h0);
    end
    rst_n = 1'b1;
    step(); step();
    check("rstm.no_pulse", 32'(done_cnt[0] + to_cnt[0] + done_cnt[1] + to_cnt[1]), 32'd0);
    req = 1'b1;
    step();
    req = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    check("rstm.fresh_done", 32'(done_cnt[0] + done_cnt[1]), 32'd2);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(63) != 0);
      sel      = 2'($urandom_range(3));
      imm      = 8'($urandom);
      off_addr = 16'($urandom);
      bus_v    = 16'($urandom);
      ld       = 1'($urandom_range(1));
      req      = ($urandom_range(3) == 0);
      we       = 1'($urandom_range(1));
      ready    = ($urandom_range(4) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mar_access_unit.md
Name: lc3_mar_access_unit

Overview:
- Parametrised successor to the LC-3 MAR address mux.
- Selects the memory address from one of four sources: extended IR immediate, computed offset address, bus value, or hold of the current MAR.
- Registers the selected address into MAR and runs a single-outstanding memory access FSM with a ready handshake and a timeout.
- Sits between the datapath address sources and the memory interface; the control FSM issues load-MAR and access requests.

Parameters:
- ADDR_W, 16: address and MAR width.
- IMM_W, 8: IR immediate field width (IMM_W < ADDR_W).
- IMM_SEXT, 0: 0 zero-extends the immediate (LC-3 TRAP vector); 1 sign-extends it.
- TIMEOUT, 15: maximum ACCESS cycles without ready before abort (≥1). Counter width is clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sel  in  2  address source: 0 = immediate, 1 = offset address, 2 = bus, 3 = hold (current MAR).
- i_offset_addr  in  ADDR_W  computed base+offset address.
- i_imm  in  IMM_W  IR immediate field.
- i_bus  in  ADDR_W  bus value.
- i_ld_mar  in  1  load MAR from the mux output.
- i_mem_req  in  1  start an access.
- i_mem_we  in  1  write (1) or read (0); sampled together with i_mem_req.
- i_mem_ready  in  1  memory completion (LC-3 R signal).
- o_mux_out  out  ADDR_W  combinational selected address.
- o_mar  out  ADDR_W  MAR register.
- o_mem_en  out  1  memory enable.
- o_mem_we  out  1  latched write enable.
- o_busy  out  1  high when state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_timeout  out  1  one-cycle abort pulse.

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE; o_mar, o_mem_en, o_mem_we, o_done, o_timeout and the counter all 0. Applies mid-access; a pending access is dropped silently with no done or timeout pulse.
- Mux (combinational):
  - Immediate: extended to ADDR_W per IMM_SEXT. Example: 8'h85 gives 16'h0085 (zero-extend) or 16'hFF85 (sign-extend).
  - sel=3: o_mux_out = o_mar.
- MAR load: if i_ld_mar=1 and state==IDLE, o_mar <= o_mux_out on that edge. i_ld_mar is ignored in all other states, so MAR is stable for the whole access.
- FSM states: IDLE, ACCESS, DONE, ABORT.
  - IDLE: i_mem_req=1 -> ACCESS. Latch o_mem_we <= i_mem_we and clear the counter.
    - If i_ld_mar and i_mem_req are in the same cycle, the access uses the newly loaded MAR.
  - ACCESS: o_mem_en=1; the counter increments each cycle.
    - i_mem_ready=1 -> DONE.
    - else if the counter == TIMEOUT-1 -> ABORT.
    - If ready arrives on the timeout cycle, ready wins.
  - DONE: o_done=1, o_mem_en=0, o_mem_we=0 -> IDLE.
  - ABORT: o_timeout=1, o_mem_en=0, o_mem_we=0 -> IDLE.
- Latency:
  - Request accepted at edge N: o_mem_en=1 from cycle N+1.
  - Ready sampled at edge M: o_done=1 and o_mem_en=0 in cycle M+1.
  - The earliest new request is accepted at edge M+2.
- i_mem_req outside IDLE: ignored, not queued.
- i_mem_ready outside ACCESS: ignored.
- o_done and o_timeout are never high together and never high for two consecutive cycles.

Decomposition:
- Shared include/package lc3_mem_pkg holds:
  - SEL_IMM/SEL_OFF/SEL_BUS/SEL_HOLD encodings.
  - FSM state localparams (2-bit).
- Sub-module lc3_addr_mux_p: the combinational parametrised mux plus extension logic, reusable by the PC mux.

Test Plan:
- Zero-extend: IMM_SEXT=0, i_sel=0, i_imm=8'h85, pulse i_ld_mar -> o_mar=16'h0085 next cycle. Repeat with IMM_SEXT=1 -> 16'hFF85.
- Read handshake: i_sel=1, i_offset_addr=16'h3001, i_ld_mar and i_mem_req (we=0) in the same cycle; ready asserted 3 cycles after o_mem_en rises -> o_mar=16'h3001; o_mem_en high exactly 3 cycles; o_done pulses 1 cycle; o_busy falls with o_done.
- Timeout: TIMEOUT=4, request a write and never assert ready -> o_mem_en high 4 cycles, o_mem_we=1 throughout; o_timeout 1-cycle pulse; no o_done; back to IDLE.
- Ready on the last timeout cycle: TIMEOUT=4, ready on ACCESS cycle 4 -> o_done=1, o_timeout stays 0.
- Ignored inputs: while busy, pulse i_ld_mar with i_bus=16'hBEEF and i_sel=2, and pulse i_mem_req -> o_mar unchanged; only one o_done; no second access.
- Reset mid-access: drop i_rst_n in ACCESS cycle 2 -> next cycle all outputs 0; no o_done or o_timeout; a fresh request afterwards completes normally.
